seq1001_frame_tx: RTL and testbench

Serial frame transmitter that drives the bitstream consumed by the team's non-overlapping Mealy 1001 sequence detectors. It accepts a parallel payload over a valid/ready handshake and emits the 4-bit sync pattern 1001, then the payload MSB first, then an enforced idle gap. It sits at the transmit end of the serial link and is the stimulus source for detector-side logic.

---
 rtl/seq1001_pkg.sv | 22 ++
 rtl/seq1001_piso.sv | 29 ++
 rtl/seq1001_frame_tx.sv | 99 +++++++++
 tb/tb_seq1001_frame_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq1001_pkg.sv
// Shared constants for the 1001 serial link: framer state type and the sync pattern.
// Used by both the transmitter and the detector side.
package seq1001_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StData,
        StGap
    } tx_state_e;

    localparam logic [3:0]  SYNC_PAT = 4'b1001;
    localparam int unsigned SyncLen  = 4;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq1001_piso.sv
// Parallel-in serial-out payload register: load a word, then shift left, MSB presented first.
module seq1001_piso
    import seq1001_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] d_i,
    output logic              msb_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end else if (shift_i) begin
            data_q <= data_q << 1;
        end
    end

    assign msb_o = data_q[DATA_W-1];

endmodule

// File: rtl/seq1001_frame_tx.sv
// Serial frame transmitter: sync pattern 1001, payload MSB first, then an idle-low gap.
// Outputs are registered from the next-state values so they line up with the state they describe.
module seq1001_frame_tx
    import seq1001_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              tx_bit_o,
    output logic              tx_en_o,
    output logic              frame_done_o
);

    localparam int unsigned     CntW     = $clog2(max3(SyncLen, DATA_W, GAP_CYC) + 1);
    localparam logic [CntW-1:0] SyncLast = CntW'(SyncLen - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
    localparam logic [CntW-1:0] GapLast  = (GAP_CYC > 0) ? CntW'(GAP_CYC - 1) : '0;

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tx_bit_q, tx_bit_d;
    logic            tx_en_q, tx_en_d;
    logic            frame_done_q, frame_done_d;
    logic            accept;
    logic            shift;
    logic            msb;

    assign in_ready_o = (state_q == StIdle) && !rst;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            StIdle: if (accept) state_d = StSync;
            StSync: if (cnt_q == SyncLast) state_d = StData;
            StData: if (cnt_q == DataLast) state_d = (GAP_CYC > 0) ? StGap : StIdle;
            StGap:  if (cnt_q == GapLast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (state_d != state_q || state_d == StIdle) begin
            cnt_d = '0;
        end
        if (rst) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    // The PISO shifts on every edge that lands in DATA, so its MSB always holds the next bit.
    assign shift = (state_d == StData);

    always_comb begin
        tx_en_d      = (state_d == StSync) || (state_d == StData);
        frame_done_d = (state_d == StData) && (cnt_d == DataLast);
        unique case (state_d)
            StSync:  tx_bit_d = SYNC_PAT[~cnt_d[1:0]];  // ~cnt == 3-cnt for a 2-bit index
            StData:  tx_bit_d = msb;
            default: tx_bit_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tx_bit_q     <= 1'b0;
            tx_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_en_q      <= tx_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    seq1001_piso #(
        .DATA_W(DATA_W)
    ) u_piso (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .shift_i(shift),
        .d_i    (in_data_i),
        .msb_o  (msb)
    );

    assign tx_bit_o     = tx_bit_q;
    assign tx_en_o      = tx_en_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seq1001_frame_tx.sv
// Directed bench for seq1001_frame_tx: an 8-bit/2-gap instance and a 1-bit/no-gap instance,
// plus a reference non-overlapping Mealy 1001 detector on the serial line.
module tb_seq1001_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_ready, a_bit, a_en, a_done;
    logic [7:0] a_data;
    logic       b_valid, b_ready, b_bit, b_en, b_done;
    logic [0:0] b_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int k;
    int hits[$];
    int h0, h1;
    logic [1:0]  det_st = 2'd0;
    logic [29:0] exp_bit, exp_en, exp_done;
    logic [5:0]  b_exp_bit, b_exp_en, b_exp_done, b_exp_rdy;
    logic [15:0] r_exp_bit, r_exp_en, r_exp_done;

    always #5 clk = ~clk;

    seq1001_frame_tx #(
        .DATA_W (8),
        .GAP_CYC(2)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (a_valid),
        .in_data_i   (a_data),
        .in_ready_o  (a_ready),
        .tx_bit_o    (a_bit),
        .tx_en_o     (a_en),
        .frame_done_o(a_done)
    );

    seq1001_frame_tx #(
        .DATA_W (1),
        .GAP_CYC(0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (b_valid),
        .in_data_i   (b_data),
        .in_ready_o  (b_ready),
        .tx_bit_o    (b_bit),
        .tx_en_o     (b_en),
        .frame_done_o(b_done)
    );

    // Reference detector: states S0, "1", "10", "100"; returns to S0 after a hit.
    always @(posedge clk) begin
        if (det_st == 2'd3 && a_bit) hits.push_back(cyc);
        case (det_st)
            2'd0:    det_st <= a_bit ? 2'd1 : 2'd0;
            2'd1:    det_st <= a_bit ? 2'd1 : 2'd2;
            2'd2:    det_st <= a_bit ? 2'd1 : 2'd3;
            default: det_st <= 2'd0;
        endcase
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        a_valid = 1'b0;
        a_data  = 8'h00;
        b_valid = 1'b0;
        b_data  = 1'b0;
        repeat (3) tick();
        a_valid = 1'b1;
        check("rst_ready_a", a_ready, 1'b0);
        check("rst_ready_b", b_ready, 1'b0);
        check("rst_en", a_en, 1'b0);
        check("rst_bit", a_bit, 1'b0);
        check("rst_done", a_done, 1'b0);
        tick();
        check("rst_valid_no_accept", a_en, 1'b0);
        a_valid = 1'b0;
        rst     = 1'b0;
        tick();
        check("post_rst_ready", a_ready, 1'b1);
        check("post_rst_en", a_en, 1'b0);

        // Frame A5: 1001 10100101, then 2 gap cycles, then idle.
        exp_bit = {12'b1001_1010_0101, 18'b0};
        a_valid = 1'b1;
        a_data  = 8'hA5;
        for (int i = 1; i <= 12; i++) begin
            tick();
            a_valid = 1'b0;
            a_data  = 8'h5A;
            check($sformatf("a5_bit%0d", i), a_bit, exp_bit[30-i]);
            check($sformatf("a5_en%0d", i), a_en, 1'b1);
            check($sformatf("a5_done%0d", i), a_done, (i == 12));
        end
        for (int i = 13; i <= 14; i++) begin
            tick();
            check($sformatf("a5_gap_en%0d", i), a_en, 1'b0);
            check($sformatf("a5_gap_bit%0d", i), a_bit, 1'b0);
            check($sformatf("a5_gap_rdy%0d", i), a_ready, 1'b0);
            check($sformatf("a5_gap_done%0d", i), a_done, 1'b0);
        end
        tick();
        check("a5_idle_rdy15", a_ready, 1'b1);

        // Back-to-back with in_valid held: 00 then FF, 2 gap + 1 idle between frames.
        exp_bit  = 30'b1001_00000000_000_1001_11111111_000;
        exp_en   = 30'b1111_11111111_000_1111_11111111_000;
        exp_done = 30'b0000_00000001_000_0000_00000001_000;
        a_valid  = 1'b1;
        a_data   = 8'h00;
        for (int i = 1; i <= 30; i++) begin
            tick();
            a_data = 8'hFF;
            if (i == 16) a_valid = 1'b0;
            check($sformatf("b2b_bit%0d", i), a_bit, exp_bit[30-i]);
            check($sformatf("b2b_en%0d", i), a_en, exp_en[30-i]);
            check($sformatf("b2b_done%0d", i), a_done, exp_done[30-i]);
        end

        // DATA_W=1, GAP_CYC=0: 1001 then the single payload bit, idle right after.
        b_exp_bit  = 6'b10011_0;
        b_exp_en   = 6'b11111_0;
        b_exp_done = 6'b00001_0;
        b_exp_rdy  = 6'b00000_1;
        b_valid    = 1'b1;
        b_data     = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            b_valid = 1'b0;
            check($sformatf("w1_bit%0d", i), b_bit, b_exp_bit[6-i]);
            check($sformatf("w1_en%0d", i), b_en, b_exp_en[6-i]);
            check($sformatf("w1_done%0d", i), b_done, b_exp_done[6-i]);
            check($sformatf("w1_rdy%0d", i), b_ready, b_exp_rdy[6-i]);
        end

        // Reset during the third payload bit, with in_valid also high.
        r_exp_bit = 16'b1001_00111100_0000;
        a_valid   = 1'b1;
        a_data    = 8'h3C;
        for (int i = 1; i <= 7; i++) begin
            tick();
            a_valid = 1'b0;
            check($sformatf("rst_mid_bit%0d", i), a_bit, r_exp_bit[16-i]);
        end
        rst     = 1'b1;
        a_valid = 1'b1;
        check("rst_mid_rdy", a_ready, 1'b0);
        tick();
        check("rst_mid_en", a_en, 1'b0);
        check("rst_mid_bit", a_bit, 1'b0);
        check("rst_mid_done", a_done, 1'b0);
        rst     = 1'b0;
        a_valid = 1'b0;
        for (int i = 9; i <= 14; i++) begin
            tick();
            check($sformatf("rst_mid_quiet_en%0d", i), a_en, 1'b0);
            check($sformatf("rst_mid_quiet_done%0d", i), a_done, 1'b0);
        end

        // Fresh frame 3C with stray in_valid pulses (data FF) in SYNC, DATA and GAP.
        r_exp_en   = 16'b1111_11111111_0000;
        r_exp_done = 16'b0000_00000001_0000;
        a_valid    = 1'b1;
        a_data     = 8'h3C;
        for (int i = 1; i <= 16; i++) begin
            tick();
            a_valid = 1'b0;
            if (i == 2 || i == 7 || i == 13) begin
                a_valid = 1'b1;
                a_data  = 8'hFF;
            end
            check($sformatf("fresh_bit%0d", i), a_bit, r_exp_bit[16-i]);
            check($sformatf("fresh_en%0d", i), a_en, r_exp_en[16-i]);
            check($sformatf("fresh_done%0d", i), a_done, r_exp_done[16-i]);
        end

        // Loopback: two 00 frames; detector fires once each, on the last sync bit.
        hits.delete();
        k       = cyc;
        a_valid = 1'b1;
        a_data  = 8'h00;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 16) a_valid = 1'b0;
        end
        h0 = (hits.size() > 0) ? hits[0] : -1;
        h1 = (hits.size() > 1) ? hits[1] : -1;
        check_int("loop_hit_count", hits.size(), 2);
        check_int("loop_hit0_cycle", h0, k + 4);
        check_int("loop_hit1_cycle", h1, k + 19);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
